// File: rtl/sfifo_param.sv
// sfifo_param: parametrised single-clock show-ahead FIFO.
//
// Depth is 2**SFIFOAW words of SFIFODW bits. Read and write pointers carry
// one extra wrap bit so that full (count == DEPTH) and empty (count == 0)
// remain distinguishable. Every status output is decoded from registered
// pointers and flags only, so nothing on the output side depends
// combinationally on wen, rnext or flush.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous reset, active-high
//   flush        synchronous empty request (clears pointers and error flags)
//   wen / wdata  write request and data
//   wqfull       FIFO full; a write in this state is refused
//   rnext        pop request
//   rqempty      FIFO empty; rdata is not valid
//   rdata        head-of-queue word (combinational from storage)
//   count        occupancy 0..DEPTH
//   almost_full  count >= AFULL_TH
//   almost_empty count <= AEMPTY_TH
//   ovf_err      sticky: write attempted while full
//   udf_err      sticky: pop attempted while empty
//
// Handshake: wen and rnext are requests sampled at posedge clk. A write is
// accepted only if wqfull is low in that cycle; a pop is accepted only if
// rqempty is low in that cycle. A refused request is dropped (not retried)
// and sets the matching sticky error flag. flush overrides both requests.

module sfifo_param #(
   parameter int SFIFODW   = 32,
   parameter int SFIFOAW   = 3,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               wen,
   output logic               wqfull,
   input  logic [SFIFODW-1:0] wdata,
   input  logic               rnext,
   output logic               rqempty,
   output logic [SFIFODW-1:0] rdata,
   output logic [SFIFOAW:0]   count,
   output logic               almost_full,
   output logic               almost_empty,
   output logic               ovf_err,
   output logic               udf_err
);

   localparam int DEPTH = 2 ** SFIFOAW;

   localparam logic [SFIFOAW:0] DEPTH_C  = DEPTH[SFIFOAW:0];
   localparam logic [SFIFOAW:0] AFULL_C  = AFULL_TH[SFIFOAW:0];
   localparam logic [SFIFOAW:0] AEMPTY_C = AEMPTY_TH[SFIFOAW:0];
   localparam logic [SFIFOAW:0] ONE_C    = (SFIFOAW + 1)'(1);

   logic [SFIFODW-1:0] mem [DEPTH];
   logic [SFIFOAW:0]   wadr;
   logic [SFIFOAW:0]   radr;
   logic               wa;
   logic               ra;

   // Occupancy is the modular pointer difference; the wrap bit makes
   // DEPTH representable.
   assign count        = wadr - radr;
   assign wqfull       = (count == DEPTH_C);
   assign rqempty      = (count == '0);
   assign almost_full  = (count >= AFULL_C);
   assign almost_empty = (count <= AEMPTY_C);

   // Accepts are qualified by registered full/empty, so at full a
   // simultaneous pop is taken and the write refused, and at empty the
   // write is taken and the pop refused.
   assign wa = wen   & ~wqfull  & ~flush;
   assign ra = rnext & ~rqempty & ~flush;

   // Show-ahead: head word is read asynchronously from storage.
   assign rdata = mem[radr[SFIFOAW-1:0]];

   // Storage has no reset; contents are meaningless while empty.
   always_ff @(posedge clk) begin
      if (!rst && wa) begin
         mem[wadr[SFIFOAW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wadr    <= '0;
         radr    <= '0;
         ovf_err <= 1'b0;
         udf_err <= 1'b0;
      end else begin
         if (wa) begin
            wadr <= wadr + ONE_C;
         end
         if (ra) begin
            radr <= radr + ONE_C;
         end
         if (wen && wqfull) begin
            ovf_err <= 1'b1;
         end
         if (rnext && rqempty) begin
            udf_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/sfifo_param.md
Name: sfifo_param

Overview:
- Parametrised single-clock FIFO; the synchronous successor to the 4-entry async FIFO in the memory-interface path.
- Generalised data width and power-of-two depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, flush, and sticky overflow/underflow error flags.
- Used between CPU-side request logic and the memory controller queues where both sides share one clock.

Parameters:
- SFIFODW, 32, data width in bits.
- SFIFOAW, 3, address width; depth DEPTH = 2**SFIFOAW (default 8).
- AFULL_TH, 6, almost_full asserted when count >= AFULL_TH (1..DEPTH).
- AEMPTY_TH, 1, almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous empty request.
- wen  input  1  write request.
- wqfull  output  1  FIFO full; write is refused.
- wdata  input  SFIFODW  write data.
- rnext  input  1  pop request; advances the read pointer.
- rqempty  output  1  FIFO empty; rdata is not valid.
- rdata  output  SFIFODW  head-of-queue data (show-ahead).
- count  output  SFIFOAW+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AFULL_TH.
- almost_empty  output  1  count <= AEMPTY_TH.
- ovf_err  output  1  sticky: write attempted while full.
- udf_err  output  1  sticky: pop attempted while empty.

Behaviour:
- Pointers: wadr and radr are SFIFOAW+1 bits wide. The MSB is the wrap bit.
  - count = wadr - radr, modulo 2**(SFIFOAW+1).
  - wqfull = (count == DEPTH). rqempty = (count == 0).
  - All flags are decoded from registered pointers only. There is no combinational path from wen or rnext to any output.
- Write accept: wa = wen & ~wqfull.
  - On accept, mem[wadr[SFIFOAW-1:0]] <= wdata and wadr increments.
- Read accept: ra = rnext & ~rqempty. On accept, radr increments.
- Show-ahead read: rdata = mem[radr[SFIFOAW-1:0]], combinational from storage. rdata is valid whenever rqempty = 0.
- Write-to-read latency: a word written at edge N is visible on rdata, with rqempty = 0, from edge N onward (one cycle).
- Full with simultaneous wen and rnext:
  - The read is accepted and the write is refused.
  - count goes to DEPTH-1.
  - ovf_err is set.
- Empty with simultaneous wen and rnext:
  - The write is accepted and the read is refused.
  - count goes to 1.
  - udf_err is set.
- Neither full nor empty, simultaneous wen and rnext: both are accepted and count is unchanged.
- Wrap-around: the pointers roll over modulo 2**(SFIFOAW+1) with no bubble. Full and empty stay distinguishable through the MSB.
- Error flags:
  - ovf_err is set by wen & wqfull.
  - udf_err is set by rnext & rqempty.
  - Both hold until rst or flush clears them.
- flush:
  - At the next edge, wadr = radr = 0 and both error flags clear.
  - flush has priority over wen and rnext in the same cycle; that cycle's wen is discarded and sets no flag.
- Reset values (rst = 1 at an edge; also the mid-operation result):
  - wadr = radr = 0, count = 0.
  - rqempty = 1, wqfull = 0.
  - almost_empty = 1 (AEMPTY_TH >= 0), almost_full = 0.
  - ovf_err = udf_err = 0.
  - rdata is undefined while empty. Storage is not reset.
- Priority order: rst > flush > normal operation.
- Storage: register array DEPTH x SFIFODW. Distributed RAM inference is allowed; read must remain asynchronous.

Test Plan:
- Reset, then 8 writes 0x11..0x88 with no reads:
  - count steps 1..8; almost_full rises when count = 6; wqfull = 1 after the 8th write.
  - A 9th write of 0x99 is refused, ovf_err = 1, and rdata stays 0x11.
- From full, 8 pops:
  - rdata sequence 0x11..0x88; almost_empty = 1 at count <= 1; rqempty = 1 after the last pop.
  - An extra pop sets udf_err = 1 and count stays 0.
- Streaming: wen = rnext = 1 for 40 cycles after one pre-write, with wdata incrementing.
  - count holds at 1 and rdata order is preserved across 5 pointer wraps.
- Simultaneous access at the boundaries:
  - At full, wen & rnext gives count = 7 and ovf_err = 1.
  - At empty, wen & rnext gives count = 1, udf_err = 1, and rdata equals the written word.
- Flush with 5 entries plus concurrent wen:
  - Next cycle count = 0, rqempty = 1, error flags 0, and the concurrent word is not stored.
- rst asserted mid-stream (count = 4, ovf_err = 1): all outputs return to their reset values at the next edge.
